// File: rtl/spawn_pkg.sv
// Shared types and the per-level release table
// for the obstacle spawn scheduler.
package spawn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FROZEN,
        DONE
    } sched_state_t;

    localparam int NUM_OBJ_DEF = 20;

    // Second at which each object slot is released.
    localparam int unsigned RELEASE_SEC [0:NUM_OBJ_DEF-1] = '{
        0, 2, 3, 3, 4, 5, 5, 6, 7, 8,
        8, 9, 10, 10, 11, 12, 12, 13, 14, 15
    };

endpackage

// File: rtl/spawn_scheduler_frame_tick_gen.sv
// Vsync falling-edge detector and frame prescaler
// producing frame and second ticks.
module frame_tick_gen #(
    parameter int FRAME_DIV = 60
) (
    input  logic Clk,
    input  logic Reset,
    input  logic vs,
    input  logic clear,
    input  logic enable,
    output logic frame_tick,
    output logic sec_tick
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic             vs_q;
    logic [CNT_W-1:0] frame_cnt;
    logic             last;

    assign last     = (frame_cnt == CNT_W'(FRAME_DIV - 1));
    assign sec_tick = enable & frame_tick & last;

    // Registered falling-edge detect on vsync, free-running in every state.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            vs_q       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_q       <= vs;
            frame_tick <= vs_q & ~vs;
        end
    end

    // Frames-per-second prescaler; only advances while play is running.
    always_ff @(posedge Clk) begin
        if (!Reset || clear) begin
            frame_cnt <= '0;
        end else if (enable && frame_tick) begin
            frame_cnt <= last ? '0 : frame_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spawn_scheduler.sv
// Level sequencer: releases falling objects on
// schedule and tracks their end of travel.
module spawn_scheduler
    import spawn_pkg::*;
#(
    parameter int NUM_OBJ   = NUM_OBJ_DEF,
    parameter int FRAME_DIV = 60,
    parameter int SEC_W     = 10
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               vs,
    input  logic               start,
    input  logic               restart,
    input  logic               collision,
    input  logic [NUM_OBJ-1:0] end_level,
    output logic [NUM_OBJ-1:0] obj_ready,
    output logic [SEC_W-1:0]   seconds,
    output logic               frame_tick,
    output logic               level_done,
    output logic               frozen
);

    sched_state_t       state;
    logic [NUM_OBJ-1:0] done_mask;
    logic [NUM_OBJ-1:0] ready_next;
    logic [NUM_OBJ-1:0] done_next;
    logic               sec_tick;
    logic               run_en;
    logic               clr;

    // Collision and restart both pre-empt counting in the same cycle.
    assign run_en = (state == RUN) & ~restart & ~collision;
    assign clr    = restart | (state == IDLE);

    frame_tick_gen #(
        .FRAME_DIV (FRAME_DIV)
    ) u_tick (
        .Clk        (Clk),
        .Reset      (Reset),
        .vs         (vs),
        .clear      (clr),
        .enable     (run_en),
        .frame_tick (frame_tick),
        .sec_tick   (sec_tick)
    );

    // Per-slot release and completion; finishing wins over release.
    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        logic due;
        logic fin;
        assign due           = 32'(seconds) >= RELEASE_SEC[i];
        assign fin           = obj_ready[i] & end_level[i];
        assign done_next[i]  = done_mask[i] | fin;
        assign ready_next[i] = ~fin & (obj_ready[i] | (~done_mask[i] & due));
    end

    // Level FSM with registered outputs, seconds counter and slot masks.
    always_ff @(posedge Clk) begin
        if (!Reset || restart) begin
            state      <= IDLE;
            seconds    <= '0;
            obj_ready  <= '0;
            done_mask  <= '0;
            level_done <= 1'b0;
            frozen     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    seconds   <= '0;
                    obj_ready <= '0;
                    done_mask <= '0;
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (collision) begin
                        state  <= FROZEN;
                        frozen <= 1'b1;
                    end else begin
                        if (sec_tick && !(&seconds))
                            seconds <= seconds + SEC_W'(1);
                        done_mask <= done_next;
                        if (&done_next) begin
                            state      <= DONE;
                            level_done <= 1'b1;
                            obj_ready  <= '0;
                        end else begin
                            obj_ready <= ready_next;
                        end
                    end
                end
                FROZEN: begin
                    frozen <= 1'b1;
                end
                DONE: begin
                    obj_ready <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
